// File: rtl/paddle_ctrl.sv
// Player paddle controller: keycode-driven velocity integration per frame,
// clamped to the play field, with pushbutton pause and recenter.
module paddle_ctrl #(
    parameter int X_MIN     = 40,
    parameter int X_MAX     = 599,
    parameter int Y_MIN     = 40,
    parameter int Y_MAX     = 439,
    parameter int X_CENTER  = 320,
    parameter int Y_CENTER  = 240,
    parameter int MAX_SPEED = 8,
    parameter int ACCEL     = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [7:0]        keycode,
    input  logic [1:0]        key,
    input  logic              frame_tick,
    output logic [9:0]        paddle_x,
    output logic [9:0]        paddle_y,
    output logic signed [4:0] vel_x,
    output logic signed [4:0] vel_y,
    output logic              paused,
    output logic              edge_hit
);

    localparam logic signed [11:0] XMin = 12'(X_MIN);
    localparam logic signed [11:0] XMax = 12'(X_MAX);
    localparam logic signed [11:0] YMin = 12'(Y_MIN);
    localparam logic signed [11:0] YMax = 12'(Y_MAX);
    localparam logic signed [11:0] Acc  = 12'(ACCEL);
    localparam logic signed [11:0] VMax = 12'(MAX_SPEED);

    typedef enum logic [0:0] {StRun, StPaused} state_e;

    state_e            state_q, state_d;
    logic [7:0]        keycode_q;
    logic [1:0]        key_s1_q, key_s2_q, key_prev_q;
    logic [1:0]        press;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic signed [4:0] vx_q, vx_d, vy_q, vy_d;
    logic              edge_q, edge_d;

    logic              go_right, go_left, go_down, go_up;
    logic signed [11:0] vx_n, vy_n, px_n, py_n;

    // Accelerate toward the pressed direction, otherwise decay to zero without overshoot.
    function automatic logic signed [11:0] step_vel(input logic signed [11:0] v,
                                                    input logic pos, input logic neg);
        logic signed [11:0] r;
        if (pos) begin
            r = v + Acc;
            if (r > VMax) r = VMax;
        end else if (neg) begin
            r = v - Acc;
            if (r < -VMax) r = -VMax;
        end else if (v > Acc) begin
            r = v - Acc;
        end else if (v < -Acc) begin
            r = v + Acc;
        end else begin
            r = '0;
        end
        return r;
    endfunction

    assign press    = key_prev_q & ~key_s2_q;
    assign go_right = (keycode_q == 8'h07);
    assign go_left  = (keycode_q == 8'h04);
    assign go_down  = (keycode_q == 8'h16);
    assign go_up    = (keycode_q == 8'h1A);

    assign vx_n = step_vel({{7{vx_q[4]}}, vx_q}, go_right, go_left);
    assign vy_n = step_vel({{7{vy_q[4]}}, vy_q}, go_down, go_up);
    assign px_n = $signed({2'b00, x_q}) + vx_n;
    assign py_n = $signed({2'b00, y_q}) + vy_n;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        edge_d  = 1'b0;

        if (press[1]) state_d = (state_q == StRun) ? StPaused : StRun;

        // Recenter wins over a coincident frame tick; that tick is dropped.
        if (press[0]) begin
            x_d  = 10'(X_CENTER);
            y_d  = 10'(Y_CENTER);
            vx_d = '0;
            vy_d = '0;
        end else if (frame_tick && state_q == StRun) begin
            x_d  = px_n[9:0];
            vx_d = vx_n[4:0];
            if (px_n < XMin) begin
                x_d    = 10'(X_MIN);
                vx_d   = '0;
                edge_d = 1'b1;
            end else if (px_n > XMax) begin
                x_d    = 10'(X_MAX);
                vx_d   = '0;
                edge_d = 1'b1;
            end
            y_d  = py_n[9:0];
            vy_d = vy_n[4:0];
            if (py_n < YMin) begin
                y_d    = 10'(Y_MIN);
                vy_d   = '0;
                edge_d = 1'b1;
            end else if (py_n > YMax) begin
                y_d    = 10'(Y_MAX);
                vy_d   = '0;
                edge_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= StRun;
            keycode_q  <= '0;
            key_s1_q   <= 2'b11;
            key_s2_q   <= 2'b11;
            key_prev_q <= 2'b11;
            x_q        <= 10'(X_CENTER);
            y_q        <= 10'(Y_CENTER);
            vx_q       <= '0;
            vy_q       <= '0;
            edge_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            keycode_q  <= keycode;
            key_s1_q   <= key;
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
            x_q        <= x_d;
            y_q        <= y_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            edge_q     <= edge_d;
        end
    end

    assign paddle_x = x_q;
    assign paddle_y = y_q;
    assign vel_x    = vx_q;
    assign vel_y    = vy_q;
    assign paused   = (state_q == StPaused);
    assign edge_hit = edge_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: table of frame steps plus hand-written
// sequences for clamping, pause, recenter-vs-tick and asynchronous reset.
module tb_paddle_ctrl;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        keycode;
    logic [1:0]        key;
    logic              frame_tick;
    logic [9:0]        paddle_x, paddle_y;
    logic signed [4:0] vel_x, vel_y;
    logic              paused, edge_hit;

    int n_tests = 0;
    int n_fail  = 0;

    paddle_ctrl dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .keycode       (keycode),
        .key           (key),
        .frame_tick    (frame_tick),
        .paddle_x      (paddle_x),
        .paddle_y      (paddle_y),
        .vel_x         (vel_x),
        .vel_y         (vel_y),
        .paused        (paused),
        .edge_hit      (edge_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] kc;
        int         x;
        int         y;
        int         vx;
        int         vy;
        int         eh;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int x, input int y, input int vx,
                           input int vy, input int p, input int eh);
        chk({name, ".x"}, int'(paddle_x), x);
        chk({name, ".y"}, int'(paddle_y), y);
        chk({name, ".vx"}, int'(vel_x), vx);
        chk({name, ".vy"}, int'(vel_y), vy);
        chk({name, ".paused"}, int'(paused), p);
        chk({name, ".edge"}, int'(edge_hit), eh);
    endtask

    // Called at a negedge; returns at the negedge right after the update edge.
    task automatic do_tick(input logic [7:0] kc);
        keycode = kc;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic press_key(input int idx);
        key[idx] = 1'b0;
        repeat (10) @(negedge clk);
        key[idx] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        int prev_x, prev_vx;

        tbl[0]  = '{8'h07, 321, 240, 1, 0, 0};
        tbl[1]  = '{8'h07, 323, 240, 2, 0, 0};
        tbl[2]  = '{8'h07, 326, 240, 3, 0, 0};
        tbl[3]  = '{8'h07, 330, 240, 4, 0, 0};
        tbl[4]  = '{8'h07, 335, 240, 5, 0, 0};
        tbl[5]  = '{8'h07, 341, 240, 6, 0, 0};
        tbl[6]  = '{8'h07, 348, 240, 7, 0, 0};
        tbl[7]  = '{8'h07, 356, 240, 8, 0, 0};
        tbl[8]  = '{8'h07, 364, 240, 8, 0, 0};
        tbl[9]  = '{8'h07, 372, 240, 8, 0, 0};
        tbl[10] = '{8'h07, 380, 240, 8, 0, 0};
        tbl[11] = '{8'h07, 388, 240, 8, 0, 0};
        tbl[12] = '{8'h00, 395, 240, 7, 0, 0};
        tbl[13] = '{8'h00, 401, 240, 6, 0, 0};
        tbl[14] = '{8'h00, 406, 240, 5, 0, 0};
        tbl[15] = '{8'h00, 410, 240, 4, 0, 0};
        tbl[16] = '{8'h00, 413, 240, 3, 0, 0};
        tbl[17] = '{8'h00, 415, 240, 2, 0, 0};
        tbl[18] = '{8'h00, 416, 240, 1, 0, 0};
        tbl[19] = '{8'h00, 416, 240, 0, 0, 0};

        rst_n      = 1'b0;
        keycode    = 8'h00;
        key        = 2'b11;
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("reset", 320, 240, 0, 0, 0, 0);

        // Acceleration, saturation and decay.
        for (int i = 0; i < 20; i++) begin
            do_tick(tbl[i].kc);
            chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].vx, tbl[i].vy, 0,
                    tbl[i].eh);
        end

        // Run into the right bound: 416 -> 452 after 8 ticks, then +8 until 604 > 599.
        n = 0;
        prev_x = 0;
        prev_vx = 0;
        edge_hit_wait: for (int i = 0; i < 40; i++) begin
            prev_x  = int'(paddle_x);
            prev_vx = int'(vel_x);
            do_tick(8'h07);
            n++;
            if (edge_hit) break;
        end
        chk("clamp.ticks", n, 27);
        chk("clamp.prev_x", prev_x, 596);
        chk("clamp.prev_vx", prev_vx, 8);
        chk_all("clamp", 599, 240, 0, 0, 0, 1);
        @(negedge clk);
        chk("clamp.edge_drop", int'(edge_hit), 0);
        do_tick(8'h07);
        chk_all("clamp2", 599, 240, 0, 0, 0, 1);
        @(negedge clk);
        chk("clamp2.edge_drop", int'(edge_hit), 0);

        // Pause freezes everything through several ticks.
        press_key(1);
        chk("pause.on", int'(paused), 1);
        for (int i = 0; i < 5; i++) do_tick(8'h16);
        chk_all("paused", 599, 240, 0, 0, 1, 0);
        press_key(1);
        chk("pause.off", int'(paused), 0);
        do_tick(8'h16);
        chk_all("resume", 599, 241, 0, 1, 0, 0);

        // Recenter on its own, then build vel_x=5 and recenter with a coincident tick.
        press_key(0);
        chk_all("recenter", 320, 240, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_tick(8'h07);
        chk_all("pre_rc", 335, 240, 5, 0, 0, 0);
        key[0] = 1'b0;
        repeat (2) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk_all("rc_tick", 320, 240, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("rc_tick_hold", 320, 240, 0, 0, 0, 0);
        key[0] = 1'b1;
        repeat (4) @(negedge clk);

        // Move left to vel_x=-4, pause, then reset between clock edges.
        for (int i = 0; i < 4; i++) do_tick(8'h04);
        chk_all("left", 310, 240, -4, 0, 0, 0);
        press_key(1);
        chk_all("left_paused", 310, 240, -4, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 320, 240, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("post_rst", 320, 240, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
